// File: rtl/reg_file_mp.sv
// Multi-port register file with a post-reset clear sequencer.
// Two write ports, NUM_RD combinational read ports, optional write-through
// bypass, and one entry (KEEP_IDX) that survives reset and the clear sweep.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int KEEP_IDX = 29
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
   input  logic                       wr0_en_i,
   input  logic [ADDR_W-1:0]          wr0_addr_i,
   input  logic [DATA_W-1:0]          wr0_data_i,
   input  logic                       wr1_en_i,
   input  logic [ADDR_W-1:0]          wr1_addr_i,
   input  logic [DATA_W-1:0]          wr1_data_i,
   output logic                       ready_o
);

   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic              KEEP_EN = (KEEP_IDX >= 0);
   localparam logic [ADDR_W-1:0] KEEP_A  = ADDR_W'(KEEP_EN ? KEEP_IDX : 0);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                ready_q, ready_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];

   logic                wr0_ok;
   logic                wr1_ok;
   logic                sweep_wr;

   // Writes land only in READY and never on a reset edge; address 0 is never stored.
   assign wr0_ok   = (state_q == ST_READY) && !rst_i && wr0_en_i && (wr0_addr_i != '0);
   assign wr1_ok   = (state_q == ST_READY) && !rst_i && wr1_en_i && (wr1_addr_i != '0);
   // The sweep zeroes entry cnt unless it is the preserved entry.
   assign sweep_wr = (state_q == ST_CLEAR) && !rst_i && !(KEEP_EN && (cnt_q == KEEP_A));

   assign ready_o  = ready_q;

   // Sequencer next state: walk cnt through every entry, then go READY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_A) begin
            state_d = ST_READY;
            ready_d = 1'b1;
         end
      end
   end

   // Sequencer registers with synchronous reset restarting the sweep.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // Array next value: sweep clear, then port 0, then port 1 so port 1 wins a collision.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (sweep_wr) begin
         mem_d[cnt_q] = '0;
      end
      if (wr0_ok) begin
         mem_d[wr0_addr_i] = wr0_data_i;
      end
      if (wr1_ok) begin
         mem_d[wr1_addr_i] = wr1_data_i;
      end
   end

   // Array storage; contents are not reset, the sweep handles clearing.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_val;

      assign ra = rd_addr_i[k*ADDR_W +: ADDR_W];

      // Read mux: zero while clearing or for address 0, else bypass, else stored entry.
      always_comb begin
         rd_val = mem_q[ra];
         if (!ready_q || (ra == '0)) begin
            rd_val = '0;
         end else if ((BYPASS != 0) && wr1_en_i && (wr1_addr_i == ra)) begin
            rd_val = wr1_data_i;
         end else if ((BYPASS != 0) && wr0_en_i && (wr0_addr_i == ra)) begin
            rd_val = wr0_data_i;
         end
      end

      assign rd_data_o[k*DATA_W +: DATA_W] = rd_val;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default build (bypass on), a no-bypass twin sharing
// the same inputs, and a small 16-bit/8-entry/3-port build with no kept entry.
module tb_reg_file_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_addr;
   logic [63:0] rd_a, rd_b;
   logic        wr0_en, wr1_en;
   logic [4:0]  wr0_addr, wr1_addr;
   logic [31:0] wr0_data, wr1_data;
   logic        ready_a, ready_b;

   logic [8:0]  c_rd_addr;
   logic [47:0] c_rd_data;
   logic        c_wr0_en, c_wr1_en;
   logic [2:0]  c_wr0_addr, c_wr1_addr;
   logic [15:0] c_wr0_data, c_wr1_data;
   logic        c_ready;

   int errors = 0;
   int checks = 0;

   // Reference state for the 32-entry builds
   logic [31:0] m [32];
   bit          m_ready;

   always #5 clk = ~clk;

   reg_file_mp dut_a (
      .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_a),
      .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
      .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
      .ready_o(ready_a)
   );

   reg_file_mp #(.BYPASS(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_b),
      .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
      .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
      .ready_o(ready_b)
   );

   reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .KEEP_IDX(-1)) dut_c (
      .clk_i(clk), .rst_i(rst), .rd_addr_i(c_rd_addr), .rd_data_o(c_rd_data),
      .wr0_en_i(c_wr0_en), .wr0_addr_i(c_wr0_addr), .wr0_data_i(c_wr0_data),
      .wr1_en_i(c_wr1_en), .wr1_addr_i(c_wr1_addr), .wr1_data_i(c_wr1_data),
      .ready_o(c_ready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected read value from the register-file rules
   function automatic logic [31:0] ref_rd(input logic [4:0] a, input bit byp);
      if (!m_ready || a == 5'd0) return 32'h0;
      if (byp && wr1_en && wr1_addr == a) return wr1_data;
      if (byp && wr0_en && wr0_addr == a) return wr0_data;
      return m[a];
   endfunction

   // Apply the writes present at the coming edge to the reference
   task automatic upd();
      if (m_ready && !rst) begin
         if (wr0_en && wr0_addr != 5'd0) m[wr0_addr] = wr0_data;
         if (wr1_en && wr1_addr != 5'd0) m[wr1_addr] = wr1_data;
      end
   endtask

   task automatic sweep_done();
      m_ready = 1'b1;
      for (int i = 0; i < 32; i++) if (i != 29) m[i] = 32'h0;
   endtask

   task automatic rd2(input logic [4:0] a0, input logic [4:0] a1, input string tag);
      rd_addr = {a1, a0};
      #1;
      chk({tag, "_a_p0"}, {32'h0, rd_a[31:0]},  {32'h0, ref_rd(a0, 1'b1)});
      chk({tag, "_a_p1"}, {32'h0, rd_a[63:32]}, {32'h0, ref_rd(a1, 1'b1)});
      chk({tag, "_b_p0"}, {32'h0, rd_b[31:0]},  {32'h0, ref_rd(a0, 1'b0)});
      chk({tag, "_b_p1"}, {32'h0, rd_b[63:32]}, {32'h0, ref_rd(a1, 1'b0)});
   endtask

   task automatic wcycle(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic e1, input logic [4:0] a1, input logic [31:0] d1);
      wr0_en = e0; wr0_addr = a0; wr0_data = d0;
      wr1_en = e1; wr1_addr = a1; wr1_data = d1;
      #1;
      upd();
      tick();
      wr0_en = 1'b0;
      wr1_en = 1'b0;
   endtask

   // Count edges after reset release until each ready rises (bounded)
   task automatic count_ready(output int na, output int nc);
      na = 0;
      nc = 0;
      for (int n = 1; n <= 100; n++) begin
         tick();
         if (ready_a && na == 0) na = n;
         if (c_ready && nc == 0) nc = n;
         if (na != 0 && nc != 0) break;
      end
   endtask

   initial begin
      int na, nc;
      logic [4:0] r0, r1;

      rst = 1'b1; rd_addr = '0;
      wr0_en = 0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 0; wr1_addr = '0; wr1_data = '0;
      c_rd_addr = '0; c_wr0_en = 0; c_wr0_addr = '0; c_wr0_data = '0;
      c_wr1_en = 0; c_wr1_addr = '0; c_wr1_data = '0;
      m_ready = 1'b0;

      // Reset state
      repeat (3) tick();
      rd_addr = {5'd29, 5'd3};
      #1;
      chk("rst_ready_a", ready_a, 1'b0);
      chk("rst_ready_c", c_ready, 1'b0);
      chk("rst_rd_a", rd_a, 64'h0);
      chk("rst_rd_b", rd_b, 64'h0);

      // Sweep timing and zero-fill
      rst = 1'b0;
      count_ready(na, nc);
      chk("sweep_len_a", na, 32);
      chk("sweep_len_c", nc, 8);
      chk("ready_b", ready_b, 1'b1);
      sweep_done();
      for (int i = 0; i < 32; i++) begin
         if (i != 29) rd2(5'(i), 5'(i), "zero_fill");
      end
      wcycle(1'b1, 5'd29, 32'h29292929, 1'b0, 5'd0, 32'h0);

      // Randomized dual writes, collisions and bypass reads
      for (int c = 0; c < 150; c++) begin
         wr0_en   = 1'($urandom_range(0, 1));
         wr0_addr = 5'($urandom_range(0, 31));
         wr0_data = $urandom;
         wr1_en   = 1'($urandom_range(0, 1));
         wr1_addr = ($urandom_range(0, 3) == 0) ? wr0_addr : 5'($urandom_range(0, 31));
         wr1_data = $urandom;
         r0 = ($urandom_range(0, 2) == 0) ? wr0_addr : 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 2) == 0) ? wr1_addr : 5'($urandom_range(0, 31));
         rd2(r0, r1, "rand");
         upd();
         tick();
      end
      wr0_en = 1'b0;
      wr1_en = 1'b0;

      // Collision on entry 5, then write to address 0
      wcycle(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h0000BBBB);
      rd2(5'd5, 5'd5, "collide");
      chk("collide_lit", rd_a[31:0], 32'h0000BBBB);
      wcycle(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0);
      rd2(5'd0, 5'd5, "zero_reg");

      // Bypass vs stored value
      wcycle(1'b1, 5'd7, 32'h00000003, 1'b0, 5'd0, 32'h0);
      wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hCAFEF00D;
      rd_addr = {5'd7, 5'd7};
      #1;
      chk("bypass_on", rd_a[31:0], 32'hCAFEF00D);
      chk("bypass_off", rd_b[31:0], 32'h00000003);
      upd();
      tick();
      wr1_en = 1'b0;
      rd2(5'd7, 5'd7, "after_bypass");

      // Kept entry survives reset
      wcycle(1'b1, 5'd29, 32'hDEADBEEF, 1'b1, 5'd28, 32'h11111111);
      rd2(5'd29, 5'd28, "pre_keep");
      rst = 1'b1; m_ready = 1'b0;
      tick();
      rst = 1'b0;
      count_ready(na, nc);
      chk("sweep2_len_a", na, 32);
      sweep_done();
      rd2(5'd29, 5'd28, "keep");
      chk("keep_lit", rd_a[31:0], 32'hDEADBEEF);

      // Reset mid-sweep, writes blocked during the sweep
      wcycle(1'b1, 5'd3, 32'h00000077, 1'b0, 5'd0, 32'h0);
      rd2(5'd3, 5'd3, "pre_mid");
      rst = 1'b1; m_ready = 1'b0;
      tick();
      rst = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      na = 0;
      for (int n = 1; n <= 100; n++) begin
         if (n == 5) begin
            rd2(5'd3, 5'd29, "during_sweep");
            chk("during_ready", ready_a, 1'b0);
         end
         if (n == 20) begin
            wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h55;
         end
         if (n == 21) wr0_en = 1'b0;
         tick();
         if (ready_a && na == 0) na = n;
         if (na != 0) break;
      end
      wr0_en = 1'b0;
      chk("mid_len_a", na, 32);
      sweep_done();
      rd2(5'd3, 5'd29, "mid_after");

      // Small variant: 16-bit, 8 entries, 3 read ports, nothing kept
      for (int i = 0; i < 8; i++) begin
         c_rd_addr = {3'(i), 3'(i), 3'(i)};
         #1;
         chk("c_zero", c_rd_data, 48'h0);
      end
      c_wr0_en = 1'b1; c_wr0_addr = 3'd6; c_wr0_data = 16'hBEEF;
      c_rd_addr = {3'd6, 3'd6, 3'd6};
      #1;
      chk("c_bypass", c_rd_data, {3{16'hBEEF}});
      tick();
      c_wr0_en = 1'b0;
      #1;
      chk("c_stored", c_rd_data, {3{16'hBEEF}});
      c_rd_addr = {3'd6, 3'd5, 3'd0};
      #1;
      chk("c_mixed", c_rd_data, {16'hBEEF, 16'h0, 16'h0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
